mem_req_ctrl: RTL

- Cache-side requester for the cache-to-main-memory line interface; drives `cache2mem_o` and consumes `mem2cache_i`.
- Takes one miss command at a time from the data-cache controller.
- Each command is an optional dirty-line writeback followed by a line refill.
- Sequences the memory req/ack handshake and returns the refilled line, or an error on timeout.

---
 rtl/mem_req_ctrl_pkg.sv | 34 +++
 rtl/mem_req_ctrl_if.sv | 17 +
 rtl/mem_req_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the cache-to-memory line requester.
package mem_req_ctrl_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;   // 16-byte lines
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int CNT_W_DEF = 11;            // 2**CNT_W must exceed TIMEOUT_CYCLES

  // Clears the byte-within-line offset of a 16-byte line address.
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_REQ = 2'd1,
    RD_REQ = 2'd2,
    DONE   = 2'd3
  } type_mem_req_state_e;

  typedef struct packed {
    logic [31:0]                  addr;
    logic [DCACHE_LINE_WIDTH-1:0] w_data;
    logic                         req;
    logic                         w_en;
  } type_cache2mem_s;

  typedef struct packed {
    logic [DCACHE_LINE_WIDTH-1:0] r_data;
    logic                         ack;
  } type_mem2cache_s;

  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Cache-to-main-memory line bus.
//
// Handshake: the cache raises req with addr/w_en/w_data stable and holds
// them until it has seen ack=1 at a rising edge. The memory samples req while
// its own ack is low and answers with a single-cycle ack one cycle later,
// ignoring req while ack is high. r_data is valid only in the ack cycle.
// A new request may start in the cycle right after the ack cycle.
interface mem_req_ctrl_if;
  import mem_req_ctrl_pkg::*;

  type_cache2mem_s cache2mem_o;
  type_mem2cache_s mem2cache_i;

  modport master (output cache2mem_o, input mem2cache_i);
  modport slave  (input cache2mem_o, output mem2cache_i);

endinterface

// File: rtl/mem_req_ctrl.sv
// Miss sequencer: optional dirty-line writeback, then a line refill, with a
// per-request ack timeout. One command in flight at a time.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_wb_i,
  input  logic [31:0]                  cmd_wb_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] cmd_wb_data_i,
  input  logic [31:0]                  cmd_rd_addr_i,
  output logic                         resp_valid_o,
  output logic [DCACHE_LINE_WIDTH-1:0] resp_data_o,
  output logic                         resp_err_o,
  mem_req_ctrl_if.master               mem_bus,
  output type_mem_req_state_e          dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  type_mem_req_state_e          state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [31:0]                  wb_addr_q, wb_addr_d;
  logic [DCACHE_LINE_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [31:0]                  rd_addr_q, rd_addr_d;
  logic [DCACHE_LINE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                         err_q, err_d;

  logic ack;
  logic cnt_at_limit;

  assign ack          = mem_bus.mem2cache_i.ack;
  assign cnt_at_limit = (cnt_q == CNT_LIMIT);

  // State and command registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      rd_addr_q   <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      rd_addr_q   <= rd_addr_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // Next state: accept in IDLE, one transaction per REQ visit, timeout abort
  // unless the ack lands in the limit cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    rd_addr_d   = rd_addr_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          wb_addr_d = line_align(cmd_wb_addr_i);
          wb_data_d = cmd_wb_data_i;
          rd_addr_d = line_align(cmd_rd_addr_i);
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = cmd_wb_i ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        if (ack) begin
          // Read data returned with a write ack is meaningless; drop it.
          cnt_d   = '0;
          state_d = RD_REQ;
        end else if (cnt_at_limit) begin
          // A failed writeback abandons the refill as well.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_REQ: begin
        if (ack) begin
          resp_data_d = mem_bus.mem2cache_i.r_data;
          state_d     = DONE;
        end else if (cnt_at_limit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state and command fields.
  always_comb begin
    cmd_ready_o                  = 1'b0;
    resp_valid_o                 = 1'b0;
    mem_bus.cache2mem_o.req      = 1'b0;
    mem_bus.cache2mem_o.w_en     = 1'b0;
    mem_bus.cache2mem_o.addr     = '0;
    mem_bus.cache2mem_o.w_data   = '0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
      end
      WB_REQ: begin
        mem_bus.cache2mem_o.req    = 1'b1;
        mem_bus.cache2mem_o.w_en   = 1'b1;
        mem_bus.cache2mem_o.addr   = wb_addr_q;
        mem_bus.cache2mem_o.w_data = wb_data_q;
      end
      RD_REQ: begin
        mem_bus.cache2mem_o.req  = 1'b1;
        mem_bus.cache2mem_o.addr = rd_addr_q;
      end
      DONE: begin
        resp_valid_o = 1'b1;
      end
      default: begin
        cmd_ready_o = 1'b0;
      end
    endcase
  end

  assign resp_data_o = resp_data_q;
  assign resp_err_o  = err_q;
  assign dbg_state_o = state_q;

endmodule
